// File: rtl/bc_round_ctrl_if.sv
// Broadcast round controller bus bundle.
// Groups the command channel, the broadcast-buffer pop channel, the lane0
// element channel and the round status flags into one interface.
//   slave  : view used by bc_round_ctrl
//   master : view used by the environment driving the controller
// Signal list:
//   cmd_valid_i/cmd_ready_o, cmd_blen_i, cmd_reuse_i  round command handshake
//   abort_i                                           kill the current round
//   bc_valid_i/bc_ready_o, bc_data_i, bc_invalidate_o broadcast buffer side
//   lane_valid_o/lane_ready_i, lane_data_o,
//   lane_last_o, lane_final_o                         lane0 operand side
//   busy_o, round_done_o                              status
interface bc_round_ctrl_if #(
    parameter int MaxBlen  = 32,
    parameter int MaxReuse = 16,
    parameter int Elen     = 32
) ();
    localparam int BlenW  = $clog2(MaxBlen + 1);
    localparam int ReuseW = $clog2(MaxReuse + 1);

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [BlenW-1:0]  cmd_blen_i;
    logic [ReuseW-1:0] cmd_reuse_i;
    logic              abort_i;
    logic              bc_valid_i;
    logic [Elen-1:0]   bc_data_i;
    logic              bc_ready_o;
    logic              bc_invalidate_o;
    logic              lane_valid_o;
    logic [Elen-1:0]   lane_data_o;
    logic              lane_ready_i;
    logic              lane_last_o;
    logic              lane_final_o;
    logic              busy_o;
    logic              round_done_o;

    modport slave (
        input  cmd_valid_i, cmd_blen_i, cmd_reuse_i, abort_i,
        input  bc_valid_i, bc_data_i, lane_ready_i,
        output cmd_ready_o, bc_ready_o, bc_invalidate_o,
        output lane_valid_o, lane_data_o, lane_last_o, lane_final_o,
        output busy_o, round_done_o
    );

    modport master (
        output cmd_valid_i, cmd_blen_i, cmd_reuse_i, abort_i,
        output bc_valid_i, bc_data_i, lane_ready_i,
        input  cmd_ready_o, bc_ready_o, bc_invalidate_o,
        input  lane_valid_o, lane_data_o, lane_last_o, lane_final_o,
        input  busy_o, round_done_o
    );
endinterface

// File: rtl/bc_round_ctrl.sv
// bc_round_ctrl: sequences broadcast rounds from the broadcast ping-pong
// buffer to lane0. Each command streams blen elements, repeated reuse times
// (the buffer replays from its first element), then releases the buffer half
// with a one-cycle invalidate.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous reset, active low
//   bus     bc_round_ctrl_if.slave (command, buffer, lane and status signals)
module bc_round_ctrl #(
    parameter int MaxBlen  = 32,
    parameter int MaxReuse = 16,
    parameter int Elen     = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    bc_round_ctrl_if.slave  bus
);
    localparam int BlenW  = $clog2(MaxBlen + 1);
    localparam int ReuseW = $clog2(MaxReuse + 1);
    localparam int ElemW  = (MaxBlen > 1) ? $clog2(MaxBlen) : 1;
    localparam int PassW  = (MaxReuse > 1) ? $clog2(MaxReuse) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, INVAL, DONE0} state_e;

    state_e            state_reg;
    logic [ElemW-1:0]  elem_cnt_reg;
    logic [PassW-1:0]  pass_cnt_reg;
    logic [BlenW-1:0]  blen_reg;
    logic [ReuseW-1:0] reuse_reg;
    logic              cmd_ready_reg;
    logic              busy_reg;
    logic              inval_reg;
    logic              done_reg;

    logic in_stream;
    logic handshake;
    logic elem_at_end;
    logic pass_at_end;
    logic last_elem;
    logic final_elem;

    // Stream phase is a zero-latency pass-through; the controller only
    // counts handshakes and flags pass/round boundaries.
    assign in_stream   = (state_reg == STREAM);
    assign handshake   = in_stream & bus.bc_valid_i & bus.lane_ready_i;
    assign elem_at_end = (BlenW'(elem_cnt_reg) == (blen_reg - BlenW'(1)));
    assign pass_at_end = (ReuseW'(pass_cnt_reg) == (reuse_reg - ReuseW'(1)));
    assign last_elem   = handshake & elem_at_end;
    assign final_elem  = last_elem & pass_at_end;

    assign bus.lane_valid_o    = in_stream & bus.bc_valid_i;
    assign bus.lane_data_o     = in_stream ? bus.bc_data_i : '0;
    assign bus.bc_ready_o      = in_stream & bus.lane_ready_i;
    assign bus.lane_last_o     = last_elem;
    assign bus.lane_final_o    = final_elem;
    assign bus.cmd_ready_o     = cmd_ready_reg;
    assign bus.busy_o          = busy_reg;
    assign bus.bc_invalidate_o = inval_reg;
    assign bus.round_done_o    = done_reg;

    // Status outputs are registered alongside the state so they reflect the
    // state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            elem_cnt_reg  <= '0;
            pass_cnt_reg  <= '0;
            blen_reg      <= '0;
            reuse_reg     <= '0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            inval_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        blen_reg      <= bus.cmd_blen_i;
                        reuse_reg     <= bus.cmd_reuse_i;
                        elem_cnt_reg  <= '0;
                        pass_cnt_reg  <= '0;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if ((bus.cmd_blen_i != '0) && (bus.cmd_reuse_i != '0)) begin
                            state_reg <= STREAM;
                        end else begin
                            // Empty round: report completion, nothing to release.
                            state_reg <= DONE0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        if (elem_at_end) begin
                            elem_cnt_reg <= '0;
                            // Hold at reuse-1 on the final element instead of wrapping.
                            if (!pass_at_end) begin
                                pass_cnt_reg <= pass_cnt_reg + PassW'(1);
                            end
                        end else begin
                            elem_cnt_reg <= elem_cnt_reg + ElemW'(1);
                        end
                    end
                    if (final_elem || bus.abort_i) begin
                        state_reg <= INVAL;
                        inval_reg <= 1'b1;
                        done_reg  <= 1'b1;
                    end
                end
                INVAL, DONE0: begin
                    state_reg     <= IDLE;
                    elem_cnt_reg  <= '0;
                    pass_cnt_reg  <= '0;
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    inval_reg     <= 1'b0;
                    done_reg      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_blen_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.cmd_valid_i && cmd_ready_reg) |-> (bus.cmd_blen_i <= BlenW'(MaxBlen)));
    a_reuse_legal : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (bus.cmd_valid_i && cmd_ready_reg) |-> (bus.cmd_reuse_i <= ReuseW'(MaxReuse)));
`endif

endmodule

// File: tb/tb_bc_round_ctrl.sv
// Randomized scoreboard bench for bc_round_ctrl. The bench plays the role of
// the broadcast buffer (replaying a stored round) and of lane0. Each command
// pushes its expected element sequence into a queue; a negedge monitor pops
// and compares on every lane handshake.
module tb_bc_round_ctrl;
    localparam int MaxBlen  = 32;
    localparam int MaxReuse = 16;
    localparam int Elen     = 32;
    localparam int BlenW    = $clog2(MaxBlen + 1);
    localparam int ReuseW   = $clog2(MaxReuse + 1);

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        fin;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    bc_round_ctrl_if #(.MaxBlen(MaxBlen), .MaxReuse(MaxReuse), .Elen(Elen)) bus ();

    bc_round_ctrl #(.MaxBlen(MaxBlen), .MaxReuse(MaxReuse), .Elen(Elen)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] bdata [0:MaxBlen-1];
    int          cur_blen = 1;
    int          bidx = 0;
    int          hs_cnt = 0;
    int          abort_at = 0;
    int          rdy_mode = 0;
    bit          gap_en = 1'b0;
    bit          tog = 1'b0;
    int          inv_cnt = 0;
    int          done_cnt = 0;
    int          rdy_hi_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Buffer and lane0 stimulus, driven just after each rising edge.
    always @(posedge clk_i) begin
        logic lr, bv, ab;
        #1;
        case (rdy_mode)
            0: lr = 1'b1;
            1: begin tog = ~tog; lr = tog; end
            default: lr = 1'($urandom_range(0, 1));
        endcase
        bv = gap_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        ab = 1'b0;
        if (abort_at != 0 && hs_cnt == abort_at - 1) begin
            lr = 1'b1;
            bv = 1'b1;
            ab = 1'b1;
        end
        bus.lane_ready_i = lr;
        bus.bc_valid_i   = bv;
        bus.abort_i      = ab;
        bus.bc_data_i    = bv ? bdata[bidx] : $urandom();
    end

    // Monitor / scoreboard.
    always @(negedge clk_i) begin : monitor
        exp_t e;
        if (rst_ni) begin
            if (bus.lane_valid_o && bus.lane_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_elem actual=%0h required=none", bus.lane_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("lane_data[%0d]", hs_cnt), bus.lane_data_o, e.data);
                    chk($sformatf("lane_last[%0d]", hs_cnt), 32'(bus.lane_last_o), 32'(e.last));
                    chk($sformatf("lane_final[%0d]", hs_cnt), 32'(bus.lane_final_o), 32'(e.fin));
                end
                hs_cnt++;
            end
            if (bus.bc_valid_i && bus.bc_ready_o) begin
                bidx = (bidx + 1 >= cur_blen) ? 0 : bidx + 1;
            end
            chk("pop_without_lane_ready", 32'(bus.bc_ready_o & ~bus.lane_ready_i), 32'd0);
            if (bus.bc_ready_o) rdy_hi_cnt++;
            if (bus.bc_invalidate_o) inv_cnt++;
            if (bus.round_done_o) done_cnt++;
        end
    end

    // Called at posedge+2 of an idle cycle; command is accepted at the next edge.
    task automatic issue(input int blen, input int reuse, input int ab_at);
        int total, n;
        chk("cmd_ready_before_cmd", 32'(bus.cmd_ready_o), 32'd1);
        for (int i = 0; i < MaxBlen; i++) bdata[i] = $urandom();
        cur_blen = (blen == 0) ? 1 : blen;
        bidx = 0;
        hs_cnt = 0;
        abort_at = ab_at;
        inv_cnt = 0;
        done_cnt = 0;
        rdy_hi_cnt = 0;
        total = blen * reuse;
        n = (ab_at != 0 && ab_at < total) ? ab_at : total;
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.data = bdata[k % blen];
            e.last = ((k % blen) == blen - 1);
            e.fin  = (k == total - 1);
            exp_q.push_back(e);
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_blen_i  = BlenW'(blen);
        bus.cmd_reuse_i = ReuseW'(reuse);
        @(posedge clk_i);
        #2;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_blen_i  = BlenW'($urandom_range(0, MaxBlen));
        bus.cmd_reuse_i = ReuseW'($urandom_range(0, MaxReuse));
    endtask

    task automatic run_round(input int blen, input int reuse, input int ab_at, input int lat);
        int cyc = 0;
        bit seen = 1'b0;
        bit has_data = (blen != 0) && (reuse != 0);
        issue(blen, reuse, ab_at);
        while (!seen && cyc < 3000) begin
            @(negedge clk_i);
            cyc++;
            if (bus.round_done_o) seen = 1'b1;
        end
        chk($sformatf("round_done_seen b%0d r%0d", blen, reuse), 32'(seen), 32'd1);
        if (lat >= 0) chk($sformatf("done_latency b%0d r%0d", blen, reuse), 32'(cyc), 32'(lat));
        chk("invalidate_at_done", 32'(bus.bc_invalidate_o), 32'(has_data));
        chk("bc_ready_at_done", 32'(bus.bc_ready_o), 32'd0);
        chk("lane_valid_at_done", 32'(bus.lane_valid_o), 32'd0);
        chk("cmd_ready_at_done", 32'(bus.cmd_ready_o), 32'd0);
        @(posedge clk_i);
        #2;
        abort_at = 0;
        chk("elements_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("invalidate_count", 32'(inv_cnt), 32'(has_data));
        chk("done_count", 32'(done_cnt), 32'd1);
        if (!has_data) chk("bc_ready_pulses", 32'(rdy_hi_cnt), 32'd0);
        chk("idle_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
        chk("idle_busy", 32'(bus.busy_o), 32'd0);
        chk("idle_done", 32'(bus.round_done_o), 32'd0);
        $display("round blen=%0d reuse=%0d abort_at=%0d cycles=%0d", blen, reuse, ab_at, cyc);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
        chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
        chk({tag, "_lane_valid"}, 32'(bus.lane_valid_o), 32'd0);
        chk({tag, "_lane_data"}, bus.lane_data_o, 32'd0);
        chk({tag, "_bc_ready"}, 32'(bus.bc_ready_o), 32'd0);
        chk({tag, "_invalidate"}, 32'(bus.bc_invalidate_o), 32'd0);
        chk({tag, "_done"}, 32'(bus.round_done_o), 32'd0);
        chk({tag, "_last"}, 32'(bus.lane_last_o), 32'd0);
        chk({tag, "_final"}, 32'(bus.lane_final_o), 32'd0);
    endtask

    initial begin
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_blen_i   = '0;
        bus.cmd_reuse_i  = '0;
        bus.abort_i      = 1'b0;
        bus.bc_valid_i   = 1'b0;
        bus.bc_data_i    = '0;
        bus.lane_ready_i = 1'b0;
        for (int i = 0; i < MaxBlen; i++) bdata[i] = '0;

        repeat (3) @(posedge clk_i);
        #3;
        check_quiet("reset");
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #2;

        rdy_mode = 0; gap_en = 1'b0;
        run_round(4, 1, 0, 5);
        run_round(8, 3, 0, 25);

        rdy_mode = 1; gap_en = 1'b1;
        run_round(4, 2, 0, -1);

        rdy_mode = 0; gap_en = 1'b0;
        run_round(0, 3, 0, 1);
        run_round(5, 0, 0, 1);
        run_round(16, 2, 5, 6);

        // Back-to-back: the second command is presented in the IDLE cycle
        // right after INVAL.
        run_round(32, 16, 0, 513);
        run_round(1, 1, 0, 2);

        for (int r = 0; r < 8; r++) begin
            rdy_mode = 2;
            gap_en = 1'($urandom_range(0, 1));
            run_round($urandom_range(1, MaxBlen), $urandom_range(1, 4), 0, -1);
        end

        // Asynchronous reset in the middle of a round.
        rdy_mode = 0; gap_en = 1'b0;
        issue(8, 2, 0);
        repeat (5) @(negedge clk_i);
        chk("busy_mid_round", 32'(bus.busy_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_quiet("async_reset");
        exp_q.delete();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #2;
        run_round(3, 2, 0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
